// File: rtl/bitmap_pixel_rmw.sv
// bitmap_pixel_rmw
//   Pixel read-modify-write controller for the 4-bpp playfield bitmap.
//   A CPU bit-mode request becomes either:
//     - a RAM read, a nibble merge and a RAM write (wr=1), or
//     - a RAM read that returns one pixel duplicated in both nibbles (wr=0).
//   Each 16-bit RAM word holds 4 pixels. Pixel p = {PIXB,PIXA} sits in
//   bits [4p+3:4p].
//
// Ports
//   clk        system clock, rising edge
//   RESETn     synchronous active-low reset
//   req        request strobe, only looked at in IDLE
//   wr         1 = pixel write, 0 = pixel read (sampled with req)
//   DRBA       word address [14:1] from the auto-increment stage
//   PIXB/PIXA  pixel select within the word
//   BD         CPU data; BD[3:0] is the pixel value, BD[7:4] is ignored
//   ram_addr   RAM word address (latched DRBA)
//   ram_rd     RAM read strobe; ram_rdata is valid the following cycle
//   ram_rdata  RAM read data
//   ram_we     RAM write strobe
//   ram_wdata  merged word to write
//   busy       high while a transaction is in progress
//   ack        one-cycle completion pulse
//   dout       last read result {pix,pix}; holds until the next read completes
module bitmap_pixel_rmw (
    input  logic        clk,
    input  logic        RESETn,
    input  logic        req,
    input  logic        wr,
    input  logic [13:0] DRBA,
    input  logic        PIXB,
    input  logic        PIXA,
    input  logic [7:0]  BD,
    output logic [13:0] ram_addr,
    output logic        ram_rd,
    input  logic [15:0] ram_rdata,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  dout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    // Request as captured at acceptance; used for the whole transaction so
    // upstream address/pixel changes mid-flight cannot disturb it.
    typedef struct packed {
        logic [13:0] addr;
        logic [1:0]  pix;
        logic [3:0]  data;
        logic        wr;
    } rmw_req_t;

    state_t      state, state_nxt;
    rmw_req_t    req_q;
    logic [15:0] buf_q;
    logic [7:0]  dout_q;
    logic [15:0] merged;
    logic [3:0]  rd_nib;

    // Upper CPU nibble has no role in bit mode.
    logic unused_bd;
    assign unused_bd = ^BD[7:4];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!RESETn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = S_READ;
            S_READ:  state_nxt = S_CAPT;
            S_CAPT:  state_nxt = req_q.wr ? S_WRITE : S_ACK;
            S_WRITE: state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    assign rd_nib = ram_rdata[{req_q.pix, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (!RESETn) begin
            req_q  <= '0;
            buf_q  <= '0;
            dout_q <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                req_q.addr <= DRBA;
                req_q.pix  <= {PIXB, PIXA};
                req_q.data <= BD[3:0];
                req_q.wr   <= wr;
            end
            // RAM read latency is one cycle, so data from the READ cycle
            // is on ram_rdata during CAPT.
            if (state == S_CAPT) begin
                buf_q <= ram_rdata;
                if (!req_q.wr) dout_q <= {rd_nib, rd_nib};
            end
        end
    end

    // Replace only the selected nibble; the other three pass through.
    always_comb begin
        merged = buf_q;
        merged[{req_q.pix, 2'b00} +: 4] = req_q.data;
    end

    // ---------------- Moore outputs ----------------
    always_comb begin
        ram_rd    = (state == S_READ);
        ram_we    = (state == S_WRITE);
        busy      = (state != S_IDLE);
        ack       = (state == S_ACK);
        ram_addr  = req_q.addr;
        ram_wdata = merged;
        dout      = dout_q;
    end

endmodule

// File: tb/tb_bitmap_pixel_rmw.sv
// Self-checking bench for bitmap_pixel_rmw. A simple synchronous RAM model
// serves the DUT; a word-level reference copy of the RAM plus the pixel
// rules predicts every strobe, address, write word and dout per cycle.
module tb_bitmap_pixel_rmw;

    logic        clk;
    logic        RESETn;
    logic        req;
    logic        wr;
    logic [13:0] DRBA;
    logic        PIXB;
    logic        PIXA;
    logic [7:0]  BD;
    logic [13:0] ram_addr;
    logic        ram_rd;
    logic [15:0] ram_rdata;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic        busy;
    logic        ack;
    logic [7:0]  dout;

    bitmap_pixel_rmw dut (
        .clk       (clk),
        .RESETn    (RESETn),
        .req       (req),
        .wr        (wr),
        .DRBA      (DRBA),
        .PIXB      (PIXB),
        .PIXA      (PIXA),
        .BD        (BD),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_rdata (ram_rdata),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .ack       (ack),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous read, latency 1; write at the edge ending the
    // write cycle. The bench preloads words through a side port.
    logic [15:0] mem [0:16383];
    logic [15:0] rdata_q;
    logic        pre_we;
    logic [13:0] pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)      mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        rdata_q <= mem[ram_addr];
    end
    assign ram_rdata = rdata_q;

    // Reference state
    logic [15:0] ref_mem [0:16383];
    logic [7:0]  exp_dout;
    logic [13:0] pool [0:7];

    int n_err;
    int n_chk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic preset(input logic [13:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic scramble();
        req  = ($urandom_range(0, 3) != 0);
        wr   = 1'($urandom);
        DRBA = 14'($urandom);
        {PIXB, PIXA} = 2'($urandom);
        BD   = 8'($urandom);
    endtask

    // One full transaction with per-cycle expectations derived from the
    // timing rules: rd in cycle 1, we in cycle 3 (writes), ack in the last
    // cycle, dout updated from cycle 3 on reads. Inputs are scrambled (req
    // mostly high) during the busy cycles; the DUT must ignore all of it.
    task automatic txn(input bit w, input logic [13:0] a, input logic [1:0] p,
                       input logic [7:0] bd);
        logic [15:0] old_w;
        logic [15:0] new_w;
        logic [3:0]  nib;
        int          len;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_rd", ram_rd, 0);
        chk("idle_we", ram_we, 0);
        chk("idle_ack", ack, 0);
        chk("idle_dout", dout, exp_dout);
        req = 1'b1; wr = w; DRBA = a; {PIXB, PIXA} = p; BD = bd;
        old_w = ref_mem[a];
        nib   = 4'((old_w >> (4 * p)) & 16'hF);
        new_w = (old_w & ~(16'hF << (4 * p))) | (16'(bd[3:0]) << (4 * p));
        len   = w ? 4 : 3;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (!w && k == 3) exp_dout = {nib, nib};
            chk("busy", busy, 1);
            chk("ram_rd", ram_rd, 32'(k == 1));
            chk("ram_we", ram_we, 32'(w && k == 3));
            chk("ack", ack, 32'(k == len));
            chk("dout", dout, exp_dout);
            if (k == 1 || (w && k == 3)) chk("ram_addr", ram_addr, a);
            if (w && k == 3) chk("ram_wdata", ram_wdata, new_w);
            scramble();
        end
        req = 1'b0;
        if (w) ref_mem[a] = new_w;
    endtask

    initial begin
        n_err = 0; n_chk = 0;
        RESETn = 1'b0; req = 1'b0; wr = 1'b0; DRBA = '0;
        PIXB = 1'b0; PIXA = 1'b0; BD = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        exp_dout = 8'h00;

        // Preload while held in reset (also covers the >=2 reset cycles).
        pool[0] = 14'h1234; pool[1] = 14'h0001; pool[2] = 14'h0200;
        for (int i = 3; i < 8; i++) pool[i] = 14'($urandom);
        for (int i = 3; i < 8; i++) preset(pool[i], 16'($urandom));
        preset(14'h1234, 16'h5678);
        preset(14'h0001, 16'hC3E1);
        preset(14'h0200, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        RESETn = 1'b1;

        // Reset values and quiet idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_addr", ram_addr, 0);
            chk("rst_rd", ram_rd, 0);
            chk("rst_we", ram_we, 0);
            chk("rst_wdata", ram_wdata, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ack", ack, 0);
            chk("rst_dout", dout, 8'h00);
        end

        // Directed cases
        txn(1'b1, 14'h1234, 2'd2, 8'hFA);   // 0x5678 -> 0x5A78
        chk("mem_1234", mem[14'h1234], ref_mem[14'h1234]);
        txn(1'b0, 14'h0001, 2'd3, 8'h00);   // dout 0xCC
        txn(1'b1, 14'h0200, 2'd0, 8'h07);
        txn(1'b1, 14'h0200, 2'd1, 8'h39);   // -> 0x0097
        txn(1'b0, 14'h0200, 2'd1, 8'h00);   // dout 0x99

        // Reset during CAPT of a write
        @(negedge clk);
        req = 1'b1; wr = 1'b1; DRBA = 14'h0200; {PIXB, PIXA} = 2'd3; BD = 8'h0F;
        @(negedge clk);                     // cycle 1 (READ)
        req = 1'b0;
        @(negedge clk);                     // cycle 2 (CAPT)
        RESETn = 1'b0;
        @(negedge clk);
        exp_dout = 8'h00;
        chk("mid_busy", busy, 0);
        chk("mid_we", ram_we, 0);
        chk("mid_ack", ack, 0);
        chk("mid_dout", dout, 8'h00);
        chk("mid_addr", ram_addr, 0);
        RESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_we", ram_we, 0);
            chk("post_busy", busy, 0);
        end
        chk("mem_0200", mem[14'h0200], ref_mem[14'h0200]);
        txn(1'b1, 14'h0200, 2'd3, 8'h0F);
        txn(1'b0, 14'h0200, 2'd3, 8'h00);

        // Randomized traffic over the address pool
        for (int t = 0; t < 60; t++) begin
            txn(1'($urandom), pool[$urandom_range(0, 7)], 2'($urandom), 8'($urandom));
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk("mem_final", mem[pool[i]], ref_mem[pool[i]]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bitmap_pixel_rmw.md
# bitmap_pixel_rmw

Pixel-level read-modify-write controller for the 4-bpp playfield bitmap. It sits directly downstream of the bitmap X/Y auto-increment address stage and consumes that stage's word address (DRBA[14:1]) and pixel select (PIXB, PIXA). It turns a single CPU bit-mode request into a RAM read, a nibble merge and a RAM write, or into a read that returns one pixel. The bitmap RAM is 16 bits wide with 4 pixels per word; pixel p = {PIXB,PIXA} occupies bits [4p+3:4p].

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on rising edge
- RESETn  in  1  reset; synchronous, active-low
- req  in  1  request strobe, sampled only in IDLE
- wr  in  1  1 = pixel write, 0 = pixel read; sampled with req
- DRBA  in  14  word address [14:1] from the auto-increment stage; sampled with req
- PIXB, PIXA  in  1 each  pixel select within the word; sampled with req
- BD  in  8  CPU data; BD[3:0] is the pixel value for writes; BD[7:4] is ignored
- ram_addr  out  14  RAM word address, from the latched DRBA
- ram_rd  out  1  RAM read strobe
- ram_rdata  in  16  RAM read data; valid in the cycle after ram_rd
- ram_we  out  1  RAM write strobe
- ram_wdata  out  16  merged word
- busy  out  1  high whenever state ≠ IDLE
- ack  out  1  one-cycle completion pulse
- dout  out  8  read result {pix,pix}; holds until the next read completes

## Operation
- FSM states: IDLE, READ, CAPT, WRITE, ACK. Outputs are Moore-decoded from state and from the latch registers.
- IDLE: when req=1, latch DRBA, {PIXB,PIXA}, BD[3:0] and wr, then go to READ. When req=0, stay in IDLE.
- READ: ram_rd=1 and ram_addr=latched address. Next state is CAPT.
- CAPT: ram_rdata is captured into the word buffer at the end of the cycle. Next state is WRITE if wr, otherwise ACK.
  - For a read, dout is loaded at the same edge with {n,n}, where n = ram_rdata[4p+3:4p].
- WRITE: ram_we=1. ram_wdata equals the buffer with nibble p replaced by the latched BD[3:0]; the other three nibbles are unchanged. Next state is ACK.
- ACK: ack=1. Next state is IDLE.
- req outside IDLE is ignored: it is not queued and has no effect on the transaction in progress. req in the ACK cycle is also ignored.
- Address and pixel-select changes on the inputs after acceptance have no effect, because the latched copies are used throughout.
- No address arithmetic is done in this block. Auto-increment is upstream and happens on its own clock phase.
- Reset (RESETn low at an edge), including mid-transaction:
  - state goes to IDLE; latches, buffer and dout clear to 0
  - an in-flight write is abandoned, so ram_we is never asserted after a reset edge

## Timing
- Reset values: ram_addr=0, ram_rd=0, ram_we=0, ram_wdata=0, busy=0, ack=0, dout=0x00.
- Let cycle 0 be the cycle in which req is sampled high in IDLE.
  - Write: ram_rd in cycle 1, capture at the end of cycle 2, ram_we in cycle 3, ack in cycle 4. busy is high in cycles 1–4.
  - Read: ram_rd in cycle 1, dout valid from cycle 3, ack in cycle 3. busy is high in cycles 1–3.
- Earliest next acceptance is the cycle after ack, giving a minimum of 5 cycles per write and 4 per read.
- ram_rd and ram_we are never high in the same cycle. Each is high for exactly one cycle per transaction.
- RAM contract: synchronous read with latency 1; the write takes effect at the edge ending the WRITE cycle.
  - Consecutive writes to the same word therefore see the previous result, with no hazard.

## Test plan
- Reset: hold RESETn low 2 cycles, then release → all outputs match the reset values; no ram_rd or ram_we until the first req.
- Write: RAM[0x1234]=0x5678; req with wr=1, DRBA=0x1234, {PIXB,PIXA}=2, BD=0xFA → ram_rd in cycle 1 at 0x1234; ram_we in cycle 3 with wdata 0x5A78; ack in cycle 4; upper nibble of BD has no effect.
- Read: RAM[0x0001]=0xC3E1; req with wr=0, pixel 3 → dout=0xCC and ack in cycle 3; ram_we never asserted; busy low in cycle 4.
- Busy drop: a second req with a different address in cycle 2 of a write → exactly one ram_we, at the first address; the second request is lost.
- Back-to-back merge: RAM[0x0200]=0x0000; write 0x7 to pixel 0, then after ack write 0x9 to pixel 1 → second ram_wdata=0x0097.
- Reset mid-operation: RESETn low during CAPT of a write → no ram_we or ack; state is IDLE and busy=0 after that edge; a fresh request afterwards completes normally.
